// File: rtl/prga_decrypt.sv
// ARC4 keystream generation and decryption stage: walks a length-prefixed
// ciphertext buffer and writes the length-prefixed plaintext buffer.
module prga_decrypt #(
  parameter int MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WAIT,
    LEN_WR,
    RD_I,
    WT_I,
    RD_J,
    WT_J,
    SW_I,
    SW_J,
    RD_P,
    WT_P,
    WR_PT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        ctb_q, ctb_d;
  logic [7:0]        pad_q, pad_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ctb_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ctb_q   <= ctb_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ctb_d     = ctb_q;
    pad_d     = pad_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = LEN_RD;
        end
      end
      LEN_RD: begin
        ct_addr = '0;
        state_d = LEN_WAIT;
      end
      LEN_WAIT: begin
        len_d   = ct_rddata;
        state_d = LEN_WR;
      end
      LEN_WR: begin
        pt_addr   = '0;
        pt_wrdata = len_q;
        pt_wren   = 1'b1;
        k_d       = MSG_AW'(1);
        state_d   = (len_q == 8'd0) ? DONE : RD_I;
      end
      RD_I: begin
        s_addr  = i_q + 8'd1;
        ct_addr = k_q;
        i_d     = i_q + 8'd1;
        state_d = WT_I;
      end
      WT_I: begin
        si_d    = s_rddata;
        ctb_d   = ct_rddata;
        j_d     = j_q + s_rddata;
        state_d = RD_J;
      end
      RD_J: begin
        s_addr  = j_q;
        state_d = WT_J;
      end
      WT_J: begin
        sj_d    = s_rddata;
        state_d = SW_I;
      end
      SW_I: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = SW_J;
      end
      SW_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = RD_P;
      end
      // Pad index from the pre-swap pair; the sum is the same after the swap.
      RD_P: begin
        s_addr  = si_q + sj_q;
        state_d = WT_P;
      end
      WT_P: begin
        pad_d   = s_rddata;
        state_d = WR_PT;
      end
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = pad_q ^ ctb_q;
        pt_wren   = 1'b1;
        if (k_q == MSG_AW'(len_q)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          state_d = RD_I;
        end
      end
      // One settling cycle before rdy returns, so completion lands 4+9L edges after the start.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
